// File: rtl/mul_issue_ctrl_if.sv
// Signal bundle between EX-stage issue logic, the multi-cycle multiplier and
// the downstream result consumer, as seen around mul_issue_ctrl.
interface mul_issue_ctrl_if #(
    parameter int DEST_W = 5
);
    // Every x_valid/x_ready pair transfers exactly one item on a rising clk edge
    // where both are high; a producer keeps valid and payload stable until then.
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [31:0]       in_src1;
    logic [31:0]       in_src2;
    logic [DEST_W-1:0] in_dest;
    logic              flush;

    logic              mul_req;
    logic              mul_signed;
    logic [31:0]       mul_x;
    logic [31:0]       mul_y;
    logic [63:0]       mul_result;
    logic              mul_complete;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;

    modport master (
        input  in_valid, in_op, in_src1, in_src2, in_dest, flush,
        input  mul_result, mul_complete, out_ready,
        output in_ready, mul_req, mul_signed, mul_x, mul_y,
        output out_valid, out_result, out_dest
    );

    modport slave (
        output in_valid, in_op, in_src1, in_src2, in_dest, flush,
        output mul_result, mul_complete, out_ready,
        input  in_ready, mul_req, mul_signed, mul_x, mul_y,
        input  out_valid, out_result, out_dest
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Sequences one multiply at a time through the multi-cycle multiplier and
// hands the selected 32-bit result word downstream; flushed ops are drained.
module mul_issue_ctrl #(
    parameter int DEST_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    mul_issue_ctrl_if.master bus,
    output logic [CNT_W-1:0] done_cnt,
    output logic [1:0]       dbg_state_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [31:0]       x_q, x_d;
    logic [31:0]       y_q, y_d;
    logic              signed_q, signed_d;
    logic              low_q, low_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [31:0]       res_q, res_d;
    logic [DEST_W-1:0] odest_q, odest_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic in_ready;
    logic accept;
    logic op_mulh;
    logic op_mulhu;

    assign in_ready = !bus.flush &&
                      (state_q == IDLE || (state_q == DONE && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    // Anything that is not exactly mulh.w or mulh.wu is handled as mul.w.
    assign op_mulh  = (bus.in_op == 3'b010);
    assign op_mulhu = (bus.in_op == 3'b100);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        signed_d = signed_q;
        low_d    = low_q;
        dest_d   = dest_q;
        res_d    = res_q;
        odest_d  = odest_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d      = bus.in_src1;
                    y_d      = bus.in_src2;
                    dest_d   = bus.in_dest;
                    signed_d = !op_mulhu;
                    low_d    = !(op_mulh || op_mulhu);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    // The multiplier only resets its counter on completion, so
                    // an aborted op must still run to its complete pulse.
                    state_d = bus.mul_complete ? IDLE : DRAIN;
                end else if (bus.mul_complete) begin
                    res_d   = low_q ? bus.mul_result[31:0] : bus.mul_result[63:32];
                    odest_d = dest_q;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (bus.mul_complete) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        x_d      = bus.in_src1;
                        y_d      = bus.in_src2;
                        dest_d   = bus.in_dest;
                        signed_d = !op_mulhu;
                        low_d    = !(op_mulh || op_mulhu);
                        state_d  = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            signed_q <= 1'b0;
            low_q    <= 1'b0;
            dest_q   <= '0;
            res_q    <= '0;
            odest_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            signed_q <= signed_d;
            low_q    <= low_d;
            dest_q   <= dest_d;
            res_q    <= res_d;
            odest_q  <= odest_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mul_req    = (state_q == BUSY) || (state_q == DRAIN);
    assign bus.mul_signed = signed_q;
    assign bus.mul_x      = x_q;
    assign bus.mul_y      = y_q;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_dest   = odest_q;
    assign done_cnt       = cnt_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a 3-cycle multiplier model, directed scenarios,
// then random traffic checked by a scoreboard and a cycle-level reference.
module tb_mul_issue_ctrl;
  localparam int DEST_W = 5;
  localparam int CNT_W  = 32;
  localparam int LAT    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] done_cnt;
  logic [1:0]       dbg_state;

  mul_issue_ctrl_if #(.DEST_W(DEST_W)) bus();

  mul_issue_ctrl #(.DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .done_cnt    (done_cnt),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DEST_W+31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] p;
    if (sgn) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else     p = {32'b0, a} * {32'b0, b};
    return p;
  endfunction

  // Architectural result of each op: low word of the product for mul.w,
  // high word of the signed or unsigned product for mulh.w / mulh.wu.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'b010:  begin p = product(a, b, 1'b1); return p[63:32]; end
      3'b100:  begin p = product(a, b, 1'b0); return p[63:32]; end
      default: begin p = product(a, b, 1'b1); return p[31:0];  end
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Multiplier model: completes on the LAT-th cycle of a request, clears its
  // counter on completion or reset, and emits stray pulses while idle.
  initial begin : mult_model
    int  cnt;
    bit  req_s, cmp_s, rst_s;
    cnt = 0;
    bus.mul_complete = 1'b0;
    bus.mul_result   = '0;
    forever begin
      @(negedge clk);
      req_s = bus.mul_req;
      cmp_s = bus.mul_complete;
      rst_s = reset;
      @(posedge clk);
      #2;
      if (rst_s || cmp_s) cnt = 0;
      else if (req_s)     cnt++;
      if (bus.mul_req) begin
        bus.mul_complete = (cnt == LAT - 1);
        bus.mul_result   = product(bus.mul_x, bus.mul_y, bus.mul_signed);
      end else begin
        bus.mul_complete = ($urandom_range(0, 7) == 0);
        bus.mul_result   = {$urandom, $urandom};
      end
    end
  end

  // Reference: at most one op in the multiplier at a time; it occupies it for
  // LAT cycles, its result is offered afterwards unless a flush hit it first.
  bit               m_busy, m_live, m_have, after_rst;
  int               m_age;
  logic [CNT_W-1:0] m_done;
  logic [31:0]      m_x, m_y;
  logic             m_sgn;

  always @(negedge clk) begin : monitor
    bit                 e_ir;
    logic [DEST_W+31:0] head;
    if (reset) begin
      m_busy = 0; m_live = 0; m_have = 0; m_age = 0;
      m_done = '0; after_rst = 1;
      exp_q.delete();
    end else begin
      if (after_rst) begin
        check("rst_mul_x", bus.mul_x, 0);
        check("rst_mul_y", bus.mul_y, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_dest", bus.out_dest, 0);
        check("rst_mul_signed", bus.mul_signed, 0);
        after_rst = 0;
      end
      e_ir = !bus.flush && !m_busy && (!m_have || bus.out_ready);
      check("mul_req", bus.mul_req, m_busy);
      check("out_valid", bus.out_valid, m_have);
      check("in_ready", bus.in_ready, e_ir);
      check("done_cnt", done_cnt, m_done);
      if (m_busy) begin
        check("mul_x", bus.mul_x, m_x);
        check("mul_y", bus.mul_y, m_y);
        check("mul_signed", bus.mul_signed, m_sgn);
      end
      if (m_have) begin
        check("scoreboard_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          head = exp_q[0];
          check("out_result", bus.out_result, head[31:0]);
          check("out_dest", bus.out_dest, head[DEST_W+31:32]);
        end
        if (bus.out_ready && !bus.flush) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_done++;
          m_have = 0;
        end
      end
      if (bus.flush) begin
        m_live = 0;
        m_have = 0;
        exp_q.delete();
      end
      if (m_busy) begin
        if (m_age == LAT) begin
          m_busy = 0;
          m_have = m_live;
        end else begin
          m_age++;
        end
      end
      if (bus.in_valid && e_ir) begin
        m_busy = 1; m_age = 1; m_live = 1;
        m_x = bus.in_src1; m_y = bus.in_src2;
        m_sgn = (bus.in_op != 3'b100);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [DEST_W-1:0] d);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_dest  = d;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready && !reset) begin
        acc = 1;
        exp_q.push_back({d, ref_result(op, a, b)});
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("issue_accepted", acc, 1);
  endtask

  task automatic wait_out(input logic [31:0] exp, input int exp_lat);
    int n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) n = i;
    end
    check("out_latency", n, exp_lat);
    check("out_result_directed", bus.out_result, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin : driver
    bit hold;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 3'b001; bus.in_src1 = '0; bus.in_src2 = '0;
    bus.in_dest = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    issue(3'b001, 32'h0000_0003, 32'hFFFF_FFFE, 5'd1);
    wait_out(32'hFFFF_FFFA, 4);
    next_cycle();
    issue(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd2);
    wait_out(32'h4000_0000, 4);
    next_cycle();
    issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    wait_out(32'hFFFF_FFFE, 4);

    // flush two cycles after the handshake, then a fresh op behind the drain
    next_cycle();
    issue(3'b001, 32'd5, 32'd5, 5'd4);
    next_cycle(); bus.flush = 1'b1;
    next_cycle(); bus.flush = 1'b0;
    issue(3'b001, 32'd7, 32'd6, 5'd5);
    wait_out(32'h0000_002A, 4);

    // five cycles of backpressure on a finished result
    next_cycle();
    bus.out_ready = 1'b0;
    issue(3'b001, 32'h0000_1234, 32'h0000_0010, 5'd6);
    wait_out(32'h0001_2340, 4);
    repeat (4) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    next_cycle();

    // back-to-back: second op accepted in the cycle the first is delivered
    issue(3'b001, 32'd9, 32'd9, 5'd7);
    issue(3'b001, 32'h10, 32'h10, 5'd8);
    wait_out(32'h0000_0100, 4);

    // reset in the middle of a multiply, then a normal op
    next_cycle();
    issue(3'b001, 32'd11, 32'd3, 5'd9);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd10);
    wait_out(32'hFFFF_FFFF, 4);
    next_cycle();

    hold = 0;
    repeat (3000) begin
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 499) == 0);
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 2) != 0);
        bus.in_op    = 3'b001 << $urandom_range(0, 2);
        bus.in_src1  = rand_opnd();
        bus.in_src2  = rand_opnd();
        bus.in_dest  = DEST_W'($urandom);
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready && !reset) begin
        exp_q.push_back({bus.in_dest, ref_result(bus.in_op, bus.in_src1, bus.in_src2)});
        hold = 0;
      end else begin
        hold = bus.in_valid;
      end
      next_cycle();
    end

    reset = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (12) next_cycle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequencing controller between the EX-stage issue logic and the multi-cycle Booth/Wallace multiplier.
- Accepts one multiply op per valid/ready handshake and latches its operands.
- Holds the multiplier's request high until it completes, then selects the low or high 32-bit result and presents it downstream with backpressure.
- Handles pipeline flush safely: the multiplier's internal counter only clears on completion, so an aborted op is drained, never abandoned.

Parameters:
- DEST_W, 5, width of the destination register tag carried alongside the op
- CNT_W, 32, width of the completed-operation counter

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream op valid
- in_ready  out  1  controller can accept an op this cycle
- in_op  in  3  one-hot: [0] mul.w, [1] mulh.w, [2] mulh.wu
- in_src1  in  32  multiplicand
- in_src2  in  32  multiplier
- in_dest  in  DEST_W  destination tag
- flush  in  1  cancel any op not yet handed downstream
- mul_req  out  1  drives multiplier request; must stay high until mul_complete
- mul_signed  out  1  1 for mul.w/mulh.w, 0 for mulh.wu
- mul_x  out  32  latched src1
- mul_y  out  32  latched src2
- mul_result  in  64  multiplier product
- mul_complete  in  1  multiplier done pulse
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  selected result word
- out_dest  out  DEST_W  tag of the result
- done_cnt  out  CNT_W  ops delivered downstream (handshakes), wraps

Behaviour:
- Reset:
  - state=IDLE; mul_req, out_valid = 0
  - mul_x, mul_y, out_result, out_dest, done_cnt = 0
  - mul_signed = 0
- States: IDLE, BUSY, DRAIN, DONE.
- in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
- Accept (in_valid && in_ready):
  - latch src1/src2 to mul_x/mul_y, op and dest
  - mul_signed = !in_op[2]
  - next state BUSY
- BUSY:
  - mul_req=1; mul_x, mul_y, mul_signed held stable.
  - On mul_complete && !flush: capture out_result = mul_result[31:0] for mul.w, else mul_result[63:32]; set out_dest; go DONE.
  - On flush && !mul_complete: go DRAIN.
  - On flush && mul_complete: discard the result, go IDLE.
- DRAIN:
  - mul_req stays 1, operands unchanged.
  - On mul_complete go IDLE; the result is discarded and out_valid is never raised.
  - flush is ignored.
- DONE:
  - out_valid=1; out_result and out_dest held stable while out_ready=0.
  - On out_ready: done_cnt+1.
  - If in_valid is also accepted that cycle, go BUSY with the new operands; otherwise go IDLE.
  - On flush: drop out_valid, go IDLE, done_cnt unchanged.
  - flush takes precedence over out_ready in the same cycle.
- mul_req is 0 in IDLE and DONE. mul_req never drops between acceptance and mul_complete.
- Latency, with handshake in cycle T and a 3-cycle multiplier:
  - mul_req high during T+1..T+3
  - mul_complete at T+3
  - out_valid from T+4
- Back-to-back throughput: one op per 4 cycles with out_ready held high.
- Illegal in_op (not one-hot): treat as mul.w.
- in_op must be one-hot when in_valid=1.
- mul_complete outside BUSY/DRAIN: ignored.
- done_cnt wraps from all-ones to 0.
- Reset in any state, including mid-BUSY/DRAIN: the controller returns to reset values. Reset clears the multiplier's counter on the same reset net, so no drain is needed.

Test Plan:
- mul.w, src1=0x00000003, src2=0xFFFFFFFE, out_ready=1 -> mul_signed=1, mul_req high 3 cycles, out_valid at T+4, out_result=0xFFFFFFFA, done_cnt=1.
- mulh.w, 0x80000000 × 0x80000000 -> out_result=0x40000000. mulh.wu, 0xFFFFFFFF × 0xFFFFFFFF -> mul_signed=0, out_result=0xFFFFFFFE.
- flush at T+2 during BUSY -> state DRAIN, mul_req stays high through mul_complete, then IDLE, no out_valid, in_ready=0 meanwhile. Next mul.w 7×6 -> out_result=0x0000002A.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_result/out_dest stable, in_ready=0. out_ready=1 -> done_cnt increments once.
- Back-to-back: out_ready=1, in_valid=1 in DONE with next op 0x10×0x10 -> accepted same cycle, second out_result=0x00000100 four cycles later.
- reset asserted mid-BUSY -> next cycle mul_req=0, out_valid=0, done_cnt=0, in_ready=1. Subsequent op completes correctly.
